// File: rtl/psum_capture_buffer_pkg.sv
// Shared types and helpers for the partial-sum capture buffer.
// Default geometry, FSM state encoding and the signed clamp helper.
package psum_capture_buffer_pkg;

  localparam int DEF_T_NUM  = 4;
  localparam int DEF_PSUM_W = 20;
  localparam int DEF_OUT_W  = 16;
  localparam int DEF_DEPTH  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic logic signed [63:0] sat_clamp(
    input logic signed [63:0] x,
    input int                 ow
  );
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (ow - 1));
    if (x > mx)      sat_clamp = mx;
    else if (x < mn) sat_clamp = mn;
    else             sat_clamp = x;
  endfunction

endpackage

// File: rtl/psum_capture_buffer_ram.sv
// One timestep bank: simple dual-port synchronous RAM, 1W1R.
// A read and a write to the same address on one edge returns the old word.
module psum_bank_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [W-1:0]  i_wd,
  input  logic          i_re,
  input  logic [AW-1:0] i_ra,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wa] <= i_wd;
    if (i_re) r_q <= r_mem[i_ra];
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/psum_capture_buffer.sv
// Captures a psum burst into T_NUM per-timestep banks with clamp/truncate,
// burst-done pulse, sticky overflow/drop/saturation flags and a read port.
module psum_capture_buffer
  import psum_capture_buffer_pkg::*;
#(
  parameter  int T_NUM  = DEF_T_NUM,
  parameter  int PSUM_W = DEF_PSUM_W,
  parameter  int OUT_W  = DEF_OUT_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int SAT_EN = 1,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int TSEL_W = (T_NUM > 1) ? $clog2(T_NUM) : 1
) (
  input  logic                    s_clk,
  input  logic                    s_rst,
  input  logic                    i_psum_valid,
  input  logic [T_NUM*PSUM_W-1:0] i_psum_data,
  input  logic                    i_clear,
  input  logic                    i_rd_en,
  input  logic [TSEL_W-1:0]       i_rd_t,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  output logic [OUT_W-1:0]        o_rd_data,
  output logic                    o_rd_valid,
  output logic [ADDR_W:0]         o_wr_count,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overflow,
  output logic                    o_drop,
  output logic                    o_sat_flag
);

  localparam int NSEL = 1 << TSEL_W;

  state_e              r_state;
  state_e              w_next;
  logic [ADDR_W:0]     r_wr_ptr;
  logic                r_done;
  logic                r_ovf;
  logic                r_drop;
  logic                r_sat;
  logic                r_rd_valid;
  logic [TSEL_W-1:0]   r_rd_t;
  logic                w_full;
  logic                w_we;
  logic [ADDR_W-1:0]   w_wa;
  logic                w_sat_any;
  logic [OUT_W-1:0]    w_wd [T_NUM];
  logic [OUT_W-1:0]    w_q  [NSEL];

  assign w_full = (r_wr_ptr == (ADDR_W+1)'(DEPTH));

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_wa   = r_wr_ptr[ADDR_W-1:0];
    if (i_clear) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_psum_valid) begin
            w_next = ST_CAPTURE;
            w_we   = 1'b1;
            w_wa   = '0;
          end
        end
        ST_CAPTURE: begin
          if (i_psum_valid) w_we = !w_full;
          else              w_next = ST_DONE;
        end
        ST_DONE: w_next = ST_DONE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    logic signed [63:0] v_x;
    logic signed [63:0] v_c;
    w_sat_any = 1'b0;
    for (int t = 0; t < T_NUM; t++) begin
      v_x = 64'(signed'(i_psum_data[t*PSUM_W +: PSUM_W]));
      v_c = sat_clamp(v_x, OUT_W);
      if (SAT_EN != 0) begin
        w_wd[t] = v_c[OUT_W-1:0];
        if (v_c != v_x) w_sat_any = 1'b1;
      end else begin
        w_wd[t] = v_x[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_wr_ptr <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_drop   <= 1'b0;
      r_sat    <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_drop   <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_done <= (r_state == ST_CAPTURE) && !i_psum_valid;
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_state == ST_CAPTURE && i_psum_valid && w_full)
        r_ovf <= 1'b1;
      if (r_state == ST_DONE && i_psum_valid) r_drop <= 1'b1;
      if (w_we && w_sat_any) r_sat <= 1'b1;
    end
  end

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_t     <= '0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) r_rd_t <= i_rd_t;
    end
  end

  // Banks beyond T_NUM read as zero so an out-of-range select needs no extra compare
  for (genvar g = 0; g < NSEL; g++) begin : g_bank
    if (g < T_NUM) begin : g_ram
      psum_bank_ram #(
        .W     (OUT_W),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
      ) u_ram (
        .i_clk     (s_clk),
        .i_we      (w_we),
        .i_wa      (w_wa),
        .i_wd      (w_wd[g]),
        .i_re      (i_rd_en),
        .i_ra      (i_rd_addr),
        .o_rd_data (w_q[g])
      );
    end else begin : g_pad
      assign w_q[g] = '0;
    end
  end

  assign o_rd_data  = r_rd_valid ? w_q[r_rd_t] : '0;
  assign o_rd_valid = r_rd_valid;
  assign o_wr_count = r_wr_ptr;
  assign o_busy     = (r_state == ST_CAPTURE);
  assign o_done     = r_done;
  assign o_overflow = r_ovf;
  assign o_drop     = r_drop;
  assign o_sat_flag = r_sat;

endmodule

// File: tb/tb_psum_capture_buffer.sv
// Bench for psum_capture_buffer: a saturating 4-lane/16-deep instance and a
// truncating 6-lane/128-deep instance checked against an array model.
module tb_psum_capture_buffer;

  localparam int AT = 4, AP = 20, AD = 16;
  localparam int BT = 6, BP = 24, BD = 128;

  typedef int         beat_a_t [AT];
  typedef logic [23:0] beat_b_t [BT];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_valid, a_clear, a_rd_en;
  logic [AT*AP-1:0] a_data;
  logic [1:0]    a_rd_t;
  logic [3:0]    a_rd_addr;
  logic [15:0]   a_rd_data;
  logic          a_rd_valid, a_busy, a_done, a_ovf, a_drop, a_sat;
  logic [4:0]    a_count;

  logic          b_valid, b_clear, b_rd_en;
  logic [BT*BP-1:0] b_data;
  logic [2:0]    b_rd_t;
  logic [6:0]    b_rd_addr;
  logic [15:0]   b_rd_data;
  logic          b_rd_valid, b_busy, b_done, b_ovf, b_drop, b_sat;
  logic [7:0]    b_count;

  psum_capture_buffer #(
    .T_NUM(AT), .PSUM_W(AP), .OUT_W(16), .DEPTH(AD), .SAT_EN(1)
  ) u_a (
    .s_clk(clk), .s_rst(rst_n),
    .i_psum_valid(a_valid), .i_psum_data(a_data), .i_clear(a_clear),
    .i_rd_en(a_rd_en), .i_rd_t(a_rd_t), .i_rd_addr(a_rd_addr),
    .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid), .o_wr_count(a_count),
    .o_busy(a_busy), .o_done(a_done), .o_overflow(a_ovf),
    .o_drop(a_drop), .o_sat_flag(a_sat)
  );

  psum_capture_buffer #(
    .T_NUM(BT), .PSUM_W(BP), .OUT_W(16), .DEPTH(BD), .SAT_EN(0)
  ) u_b (
    .s_clk(clk), .s_rst(rst_n),
    .i_psum_valid(b_valid), .i_psum_data(b_data), .i_clear(b_clear),
    .i_rd_en(b_rd_en), .i_rd_t(b_rd_t), .i_rd_addr(b_rd_addr),
    .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid), .o_wr_count(b_count),
    .o_busy(b_busy), .o_done(b_done), .o_overflow(b_ovf),
    .o_drop(b_drop), .o_sat_flag(b_sat)
  );

  int n_checks = 0;
  int n_pass = 0;

  int          mem_a [AT][AD];
  logic [15:0] mem_b [BT][BD];
  beat_a_t     qa[$];
  beat_b_t     qb[$];
  logic        ovf_hist[$];
  int          done_cnt;
  logic        end_busy;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int conv_a(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int rnd20();
    return int'($urandom_range(1048575)) - 524288;
  endfunction

  function automatic logic [AT*AP-1:0] pack_a(input beat_a_t b);
    logic [AT*AP-1:0] p;
    for (int t = 0; t < AT; t++) p[t*AP +: AP] = 20'(b[t]);
    return p;
  endfunction

  function automatic logic [BT*BP-1:0] pack_b(input beat_b_t b);
    logic [BT*BP-1:0] p;
    for (int t = 0; t < BT; t++) p[t*BP +: BP] = b[t];
    return p;
  endfunction

  task automatic clear_a();
    a_clear = 1'b1; tick(); a_clear = 1'b0;
  endtask

  task automatic clear_b();
    b_clear = 1'b1; tick(); b_clear = 1'b0;
  endtask

  task automatic run_burst_a();
    done_cnt = 0;
    ovf_hist.delete();
    foreach (qa[i]) begin
      a_data = pack_a(qa[i]);
      a_valid = 1'b1;
      tick();
      done_cnt += int'(a_done);
      ovf_hist.push_back(a_ovf);
      if (i < AD) for (int t = 0; t < AT; t++) mem_a[t][i] = conv_a(qa[i][t]);
    end
    a_valid = 1'b0;
    tick();
    done_cnt += int'(a_done);
    end_busy = a_busy;
    tick();
    done_cnt += int'(a_done);
  endtask

  task automatic run_burst_b();
    done_cnt = 0;
    foreach (qb[i]) begin
      b_data = pack_b(qb[i]);
      b_valid = 1'b1;
      tick();
      done_cnt += int'(b_done);
      for (int t = 0; t < BT; t++) mem_b[t][i] = qb[i][t][15:0];
    end
    b_valid = 1'b0;
    tick();
    done_cnt += int'(b_done);
    end_busy = b_busy;
    tick();
    done_cnt += int'(b_done);
  endtask

  task automatic read_a(input int t, input int addr, output int d, output logic v);
    a_rd_en = 1'b1;
    a_rd_t = 2'(t);
    a_rd_addr = 4'(addr);
    tick();
    d = int'($signed(a_rd_data));
    v = a_rd_valid;
    a_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (a_count !== 5'd0) $display("FAIL reset_count got %0d want 0", a_count); else n_pass++;
    n_checks++; if ({a_busy, a_done, a_ovf, a_drop, a_sat} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {a_busy, a_done, a_ovf, a_drop, a_sat}); else n_pass++;
    n_checks++; if ({a_rd_valid, a_rd_data} !== 17'd0)
      $display("FAIL reset_rd got %0b/%0h want 0/0", a_rd_valid, a_rd_data); else n_pass++;
    n_checks++; if ({b_count, b_busy, b_done, b_rd_valid} !== 11'd0)
      $display("FAIL reset_b got %0d/%b%b%b want 0/000", b_count, b_busy, b_done, b_rd_valid); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_burst();
    int d; logic v;
    clear_a();
    qa.delete();
    for (int b = 0; b < 8; b++) begin
      beat_a_t x;
      for (int t = 0; t < AT; t++) x[t] = b * 10 + t;
      qa.push_back(x);
    end
    run_burst_a();
    n_checks++; if (done_cnt !== 1) $display("FAIL burst_done_pulses got %0d want 1", done_cnt); else n_pass++;
    n_checks++; if (end_busy !== 1'b0) $display("FAIL burst_busy_at_done got %b want 0", end_busy); else n_pass++;
    n_checks++; if (a_count !== 5'd8) $display("FAIL burst_count got %0d want 8", a_count); else n_pass++;
    read_a(2, 5, d, v);
    n_checks++; if (d !== 52 || v !== 1'b1) $display("FAIL burst_bank2_5 got %0d/%b want 52/1", d, v); else n_pass++;
    for (int b = 0; b < 8; b++)
      for (int t = 0; t < AT; t++) begin
        read_a(t, b, d, v);
        n_checks++; if (d !== mem_a[t][b]) $display("FAIL burst_rd t%0d a%0d got %0d want %0d", t, b, d, mem_a[t][b]); else n_pass++;
      end
  endtask

  task automatic test_saturation();
    int d; logic v;
    beat_a_t x;
    clear_a();
    qa.delete();
    for (int b = 0; b < 6; b++) begin
      for (int t = 0; t < AT; t++) x[t] = int'($urandom_range(65535)) - 32768;
      qa.push_back(x);
    end
    run_burst_a();
    n_checks++; if (a_sat !== 1'b0) $display("FAIL sat_inrange_flag got %b want 0", a_sat); else n_pass++;
    clear_a();
    qa.delete();
    for (int b = 0; b < 4; b++) begin
      for (int t = 0; t < AT; t++) x[t] = rnd20();
      if (b == 0) x[0] = 40000;
      if (b == 1) x[0] = -40000;
      qa.push_back(x);
    end
    run_burst_a();
    n_checks++; if (a_sat !== 1'b1) $display("FAIL sat_flag got %b want 1", a_sat); else n_pass++;
    read_a(0, 0, d, v);
    n_checks++; if (d !== 32767) $display("FAIL sat_pos got %0d want 32767", d); else n_pass++;
    read_a(0, 1, d, v);
    n_checks++; if (d !== -32768) $display("FAIL sat_neg got %0d want -32768", d); else n_pass++;
    for (int b = 0; b < 4; b++)
      for (int t = 1; t < AT; t++) begin
        read_a(t, b, d, v);
        n_checks++; if (d !== mem_a[t][b]) $display("FAIL sat_rd t%0d a%0d got %0d want %0d", t, b, d, mem_a[t][b]); else n_pass++;
      end
  endtask

  task automatic test_overflow();
    int d; logic v;
    beat_a_t x;
    clear_a();
    qa.delete();
    for (int b = 0; b < 20; b++) begin
      for (int t = 0; t < AT; t++) x[t] = rnd20();
      qa.push_back(x);
    end
    run_burst_a();
    n_checks++; if (ovf_hist[15] !== 1'b0) $display("FAIL ovf_at_full got %b want 0", ovf_hist[15]); else n_pass++;
    n_checks++; if (ovf_hist[16] !== 1'b1) $display("FAIL ovf_after_full got %b want 1", ovf_hist[16]); else n_pass++;
    n_checks++; if (a_count !== 5'(AD)) $display("FAIL ovf_count got %0d want %0d", a_count, AD); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL ovf_done_pulses got %0d want 1", done_cnt); else n_pass++;
    read_a(0, 15, d, v);
    n_checks++; if (d !== conv_a(qa[15][0])) $display("FAIL ovf_bank0_15 got %0d want %0d", d, conv_a(qa[15][0])); else n_pass++;
    for (int b = 0; b < AD; b++) begin
      read_a(b % AT, b, d, v);
      n_checks++; if (d !== mem_a[b % AT][b]) $display("FAIL ovf_rd a%0d got %0d want %0d", b, d, mem_a[b % AT][b]); else n_pass++;
    end
  endtask

  task automatic test_drop_clear();
    int d; logic v;
    beat_a_t x;
    a_data = pack_a('{1, 2, 3, 4});
    a_valid = 1'b1; tick(); a_valid = 1'b0;
    n_checks++; if (a_drop !== 1'b1) $display("FAIL drop_flag got %b want 1", a_drop); else n_pass++;
    n_checks++; if (a_count !== 5'(AD) || a_busy !== 1'b0)
      $display("FAIL drop_hold got %0d/%b want %0d/0", a_count, a_busy, AD); else n_pass++;
    clear_a();
    n_checks++; if ({a_count, a_drop, a_ovf, a_sat} !== 8'd0)
      $display("FAIL clear_state got %0d/%b%b%b want 0/000", a_count, a_drop, a_ovf, a_sat); else n_pass++;
    for (int b = 0; b < 3; b++) begin
      for (int t = 0; t < AT; t++) x[t] = rnd20();
      a_data = pack_a(x); a_valid = 1'b1; tick();
      for (int t = 0; t < AT; t++) mem_a[t][b] = conv_a(x[t]);
    end
    a_data = pack_a('{7, 7, 7, 7});
    a_clear = 1'b1; tick(); a_clear = 1'b0; a_valid = 1'b0;
    n_checks++; if ({a_count, a_busy, a_done} !== 7'd0)
      $display("FAIL abort_state got %0d/%b%b want 0/00", a_count, a_busy, a_done); else n_pass++;
    done_cnt = 0;
    repeat (3) begin tick(); done_cnt += int'(a_done); end
    n_checks++; if (done_cnt !== 0) $display("FAIL abort_no_done got %0d want 0", done_cnt); else n_pass++;
    read_a(1, 0, d, v);
    n_checks++; if (d !== mem_a[1][0]) $display("FAIL reburst_addr0 got %0d want %0d", d, mem_a[1][0]); else n_pass++;
    read_a(0, 3, d, v);
    n_checks++; if (d !== mem_a[0][3]) $display("FAIL abort_beat_dropped got %0d want %0d", d, mem_a[0][3]); else n_pass++;
  endtask

  task automatic test_collision();
    int old_v;
    int new_v;
    int d;
    old_v = mem_a[0][0];
    new_v = (old_v == 1234) ? 4321 : 1234;
    a_data = pack_a('{new_v, 0, 0, 0});
    a_valid = 1'b1;
    a_rd_en = 1'b1; a_rd_t = 2'd0; a_rd_addr = 4'd0;
    tick();
    a_valid = 1'b0;
    d = int'($signed(a_rd_data));
    n_checks++; if (d !== old_v) $display("FAIL collision_old got %0d want %0d", d, old_v); else n_pass++;
    tick();
    a_rd_en = 1'b0;
    d = int'($signed(a_rd_data));
    n_checks++; if (d !== new_v) $display("FAIL collision_new got %0d want %0d", d, new_v); else n_pass++;
    mem_a[0][0] = new_v;
    mem_a[1][0] = 0; mem_a[2][0] = 0; mem_a[3][0] = 0;
  endtask

  task automatic test_reset_mid();
    beat_a_t x;
    clear_a();
    for (int b = 0; b < 3; b++) begin
      for (int t = 0; t < AT; t++) x[t] = rnd20();
      a_data = pack_a(x); a_valid = 1'b1; tick();
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({a_count, a_busy, a_done, a_ovf, a_drop, a_sat, a_rd_valid} !== 11'd0)
      $display("FAIL midrst_outputs got %0d/%b%b%b%b%b%b want all 0", a_count, a_busy, a_done, a_ovf, a_drop, a_sat, a_rd_valid); else n_pass++;
    tick();
    a_valid = 1'b0;
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (3) begin tick(); done_cnt += int'(a_done); end
    n_checks++; if (done_cnt !== 0 || a_busy !== 1'b0) $display("FAIL midrst_no_done got %0d/%b want 0/0", done_cnt, a_busy); else n_pass++;
    qa.delete();
    for (int b = 0; b < 5; b++) begin
      for (int t = 0; t < AT; t++) x[t] = rnd20();
      qa.push_back(x);
    end
    run_burst_a();
    n_checks++; if (a_count !== 5'd5 || done_cnt !== 1)
      $display("FAIL midrst_reburst got %0d/%0d want 5/1", a_count, done_cnt); else n_pass++;
  endtask

  task automatic test_truncate();
    beat_b_t x;
    clear_b();
    qb.delete();
    for (int t = 0; t < BT; t++) x[t] = 24'($urandom());
    x[0] = 24'h0A0005;
    qb.push_back(x);
    run_burst_b();
    b_rd_en = 1'b1; b_rd_t = 3'd0; b_rd_addr = 7'd0;
    tick();
    b_rd_en = 1'b0;
    n_checks++; if (b_rd_data !== 16'h0005) $display("FAIL trunc_lane0 got %0h want 5", b_rd_data); else n_pass++;
    n_checks++; if (b_sat !== 1'b0 || b_count !== 8'd1)
      $display("FAIL trunc_flags got %b/%0d want 0/1", b_sat, b_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    beat_b_t x;
    int len;
    int t;
    int ad;
    logic [15:0] exp_d;
    for (int r = 0; r < 3; r++) begin
      len = (r == 0) ? 100 : int'($urandom_range(1, 100));
      clear_b();
      qb.delete();
      for (int b = 0; b < len; b++) begin
        for (int k = 0; k < BT; k++) x[k] = 24'($urandom());
        qb.push_back(x);
      end
      run_burst_b();
      n_checks++; if (b_count !== 8'(len) || done_cnt !== 1 || b_ovf !== 1'b0)
        $display("FAIL rand_burst%0d got %0d/%0d/%b want %0d/1/0", r, b_count, done_cnt, b_ovf, len); else n_pass++;
      for (int k = 0; k < 40; k++) begin
        t = (k < 2) ? 6 + k : int'($urandom_range(7));
        ad = int'($urandom_range(len - 1));
        b_rd_en = 1'b1; b_rd_t = 3'(t); b_rd_addr = 7'(ad);
        tick();
        exp_d = (t < BT) ? mem_b[t][ad] : 16'h0;
        n_checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== exp_d)
          $display("FAIL b2b_rd t%0d a%0d got %b/%0h want 1/%0h", t, ad, b_rd_valid, b_rd_data, exp_d); else n_pass++;
      end
      b_rd_en = 1'b0;
      tick();
      n_checks++; if (b_rd_valid !== 1'b0) $display("FAIL b2b_valid_drop got %b want 0", b_rd_valid); else n_pass++;
    end
  endtask

  initial begin
    a_valid = 0; a_clear = 0; a_rd_en = 0; a_data = '0; a_rd_t = '0; a_rd_addr = '0;
    b_valid = 0; b_clear = 0; b_rd_en = 0; b_data = '0; b_rd_t = '0; b_rd_addr = '0;
    test_reset();
    test_burst();
    test_saturation();
    test_overflow();
    test_drop_clear();
    test_collision();
    test_reset_mid();
    test_truncate();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
